// File: rtl/mar_mem_responder.sv
// Memory-side responder for the MAR address: captures a request, waits a programmable
// number of wait states, then performs one RAM access and returns a one-cycle ack.
module mar_mem_responder #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 8192,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q,   ack_d;
    logic              err_q,   err_d;
    logic              busy_q,  busy_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;
    logic              mem_we_c;

    // Unsigned range check on the captured address; no wrap into the array.
    assign in_range_c = (32'(addr_q) < DEPTH);
    assign idx_c      = IDX_W'(addr_q);

    // State register and registered datapath/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = ack_q;
        err_d    = err_q;
        busy_d   = busy_q;
        mem_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    ack_d = 1'b1;
                    err_d = ~in_range_c;
                    if (we_q) begin
                        mem_we_c = in_range_c;
                    end else begin
                        rdata_d = in_range_c ? mem[idx_c] : '0;
                    end
                end
            end
            S_DONE: begin
                ack_d  = 1'b0;
                err_d  = 1'b0;
                busy_d = 1'b0;
            end
            default: begin
                ack_d  = 1'b0;
                err_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule
